// File: rtl/llc_bus_ctrl.sv
// llc_bus_ctrl: runs one LLC bus operation at a time. It broadcasts a snoop,
// merges the remote snoop results (HITM > HIT > NOHIT), issues the memory
// read or write, and returns the combined snoop result to the LLC.
module llc_bus_ctrl #(
    parameter int unsigned NUM_SNOOPERS  = 3,
    parameter int unsigned SNOOP_TIMEOUT = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [2:0]                  req_op,
    input  logic [31:0]                 req_addr,
    output logic                        resp_valid,
    output logic [1:0]                  resp_snoop,
    output logic                        snp_valid,
    output logic [2:0]                  snp_op,
    output logic [31:0]                 snp_addr,
    input  logic [NUM_SNOOPERS-1:0]     snp_resp_valid,
    input  logic [2*NUM_SNOOPERS-1:0]   snp_resp,
    output logic                        mem_cmd_valid,
    input  logic                        mem_cmd_ready,
    output logic                        mem_cmd_write,
    output logic [31:0]                 mem_cmd_addr,
    input  logic                        mem_done,
    output logic                        proto_err,
    output logic [31:0]                 cnt_hitm,
    output logic [31:0]                 cnt_timeout
);

    localparam int unsigned TMR_W = $clog2(SNOOP_TIMEOUT) + 1;

    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;
    localparam logic [2:0] OP_INV   = 3'd3;
    localparam logic [2:0] OP_RWIM  = 3'd4;

    localparam logic [1:0] SNP_NOHIT = 2'd0;
    localparam logic [1:0] SNP_HITM  = 2'd2;
    localparam logic [1:0] SNP_RSVD  = 2'd3;

    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFC0;

    typedef enum logic [2:0] {
        S_IDLE, S_SNOOP, S_COLLECT, S_MEM_CMD, S_MEM_WAIT, S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [2:0]              op_q, op_d;
    logic [31:0]             addr_q, addr_d;
    logic                    wr_q, wr_d;
    logic [NUM_SNOOPERS-1:0] mask_q, mask_d, mask_m;
    logic [1:0]              comb_q, comb_d, comb_m, sr;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic                    proto_q, proto_d;
    logic [31:0]             hitm_q, hitm_d, tmo_q, tmo_d;
    logic                    dup_hitm, all_in, collect_done;

    logic                    req_ready_q, req_ready_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [1:0]              resp_snoop_q, resp_snoop_d;
    logic                    snp_valid_q, snp_valid_d;
    logic                    mem_cmd_valid_q, mem_cmd_valid_d;
    logic                    mem_cmd_write_q, mem_cmd_write_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Merge this cycle's first-time snoop responses into mask and combined result
    always_comb begin
        mask_m   = mask_q;
        comb_m   = comb_q;
        dup_hitm = 1'b0;
        sr       = SNP_NOHIT;
        for (int unsigned i = 0; i < NUM_SNOOPERS; i++) begin
            if (snp_resp_valid[i] && !mask_q[i]) begin
                mask_m[i] = 1'b1;
                sr = snp_resp[2*i +: 2];
                if (sr == SNP_RSVD) sr = SNP_NOHIT;
                if (sr == SNP_HITM && comb_m == SNP_HITM) dup_hitm = 1'b1;
                if (sr > comb_m) comb_m = sr;
            end
        end
        all_in       = &mask_m;
        collect_done = all_in || (timer_q == TMR_W'(SNOOP_TIMEOUT - 1));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        OP_READ, OP_RWIM, OP_INV: state_d = S_SNOOP;
                        OP_WRITE:                 state_d = S_MEM_CMD;
                        default:                  state_d = S_RESP;
                    endcase
                end
            end
            S_SNOOP:    state_d = S_COLLECT;
            S_COLLECT:  if (collect_done) state_d = (op_q == OP_INV) ? S_RESP : S_MEM_CMD;
            S_MEM_CMD:  if (mem_cmd_ready) state_d = S_MEM_WAIT;
            S_MEM_WAIT: if (mem_done) state_d = S_RESP;
            S_RESP:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Transaction datapath: latch request, track snoop collection, counters
    always_comb begin
        op_d    = op_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        mask_d  = mask_q;
        comb_d  = comb_q;
        timer_d = timer_q;
        proto_d = proto_q;
        hitm_d  = hitm_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d   = req_op;
                    addr_d = req_addr & LINE_MASK;
                    wr_d   = (req_op == OP_WRITE);
                    comb_d = SNP_NOHIT;
                end
            end
            S_SNOOP: begin
                mask_d  = '0;
                comb_d  = SNP_NOHIT;
                timer_d = '0;
            end
            S_COLLECT: begin
                mask_d  = mask_m;
                comb_d  = comb_m;
                timer_d = timer_q + TMR_W'(1);
                proto_d = proto_q | dup_hitm;
                if (collect_done) begin
                    wr_d = (comb_m == SNP_HITM);
                    if (!all_in) tmo_d = sat_inc(tmo_q);
                    if (op_q != OP_INV && comb_m == SNP_HITM) hitm_d = sat_inc(hitm_q);
                end
            end
            default: ;
        endcase
    end

    // Output decode from the upcoming state so every output comes from a flop
    always_comb begin
        req_ready_d     = (state_d == S_IDLE);
        snp_valid_d     = (state_d == S_SNOOP);
        mem_cmd_valid_d = (state_d == S_MEM_CMD);
        mem_cmd_write_d = (state_d == S_MEM_CMD) && wr_d;
        resp_valid_d    = (state_d == S_RESP);
        resp_snoop_d    = resp_snoop_q;
        if (state_d == S_RESP) resp_snoop_d = comb_d;
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q            <= '0;
            addr_q          <= '0;
            wr_q            <= 1'b0;
            mask_q          <= '0;
            comb_q          <= SNP_NOHIT;
            timer_q         <= '0;
            proto_q         <= 1'b0;
            hitm_q          <= '0;
            tmo_q           <= '0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_snoop_q    <= SNP_NOHIT;
            snp_valid_q     <= 1'b0;
            mem_cmd_valid_q <= 1'b0;
            mem_cmd_write_q <= 1'b0;
        end else begin
            op_q            <= op_d;
            addr_q          <= addr_d;
            wr_q            <= wr_d;
            mask_q          <= mask_d;
            comb_q          <= comb_d;
            timer_q         <= timer_d;
            proto_q         <= proto_d;
            hitm_q          <= hitm_d;
            tmo_q           <= tmo_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_snoop_q    <= resp_snoop_d;
            snp_valid_q     <= snp_valid_d;
            mem_cmd_valid_q <= mem_cmd_valid_d;
            mem_cmd_write_q <= mem_cmd_write_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_snoop    = resp_snoop_q;
    assign snp_valid     = snp_valid_q;
    assign snp_op        = op_q;
    assign snp_addr      = addr_q;
    assign mem_cmd_valid = mem_cmd_valid_q;
    assign mem_cmd_write = mem_cmd_write_q;
    assign mem_cmd_addr  = addr_q;
    assign proto_err     = proto_q;
    assign cnt_hitm      = hitm_q;
    assign cnt_timeout   = tmo_q;

endmodule

// File: tb/tb_llc_bus_ctrl.sv
// Testbench for llc_bus_ctrl: directed scenarios plus randomized transactions
// checked against a cycle-count reference model of the bus protocol.
module tb_llc_bus_ctrl;

    localparam int T    = 8;
    localparam int MAXC = 60;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic        resp_valid;
    logic [1:0]  resp_snoop;
    logic        snp_valid;
    logic [2:0]  snp_op;
    logic [31:0] snp_addr;
    logic [2:0]  snp_resp_valid = '0;
    logic [5:0]  snp_resp = '0;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready = 1'b0;
    logic        mem_cmd_write;
    logic [31:0] mem_cmd_addr;
    logic        mem_done = 1'b0;
    logic        proto_err;
    logic [31:0] cnt_hitm, cnt_timeout;

    llc_bus_ctrl #(.NUM_SNOOPERS(3), .SNOOP_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_snoop(resp_snoop),
        .snp_valid(snp_valid), .snp_op(snp_op), .snp_addr(snp_addr),
        .snp_resp_valid(snp_resp_valid), .snp_resp(snp_resp),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_write(mem_cmd_write), .mem_cmd_addr(mem_cmd_addr), .mem_done(mem_done),
        .proto_err(proto_err), .cnt_hitm(cnt_hitm), .cnt_timeout(cnt_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          resp_cyc;
        int          resp_cnt;
        logic [1:0]  snoop;
        int          snp_cnt;
        int          snp_cyc;
        logic [31:0] snp_addr;
        int          mem_cnt;
        int          mem_first;
        logic        mem_write;
        logic        wr_hold;
        logic [31:0] mem_addr;
        logic        rdy_ok;
        logic        op_ok;
    } obs_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          rc_s[3];
    logic [1:0]  rv_s[3];
    logic        exp_proto = 1'b0;
    logic [31:0] exp_hitm = '0;
    logic [31:0] exp_tmo = '0;

    function automatic string fmt(input obs_t o);
        return $sformatf("resp@%0d x%0d snoop=%0d snp@%0d x%0d addr=%h mem@%0d x%0d wr=%0b hold=%0b maddr=%h rdy=%0b op=%0b",
                         o.resp_cyc, o.resp_cnt, o.snoop, o.snp_cyc, o.snp_cnt, o.snp_addr,
                         o.mem_first, o.mem_cnt, o.mem_write, o.wr_hold, o.mem_addr, o.rdy_ok, o.op_ok);
    endfunction

    task automatic set_sched(input int r0, input int r1, input int r2,
                             input logic [1:0] v0, input logic [1:0] v1, input logic [1:0] v2);
        rc_s[0] = r0; rc_s[1] = r1; rc_s[2] = r2;
        rv_s[0] = v0; rv_s[1] = v1; rv_s[2] = v2;
    endtask

    // Reference model: cycle numbers relative to the accept edge (cycle 1 = first cycle after it)
    task automatic model_txn(input logic [2:0] op, input logic [31:0] addr, input int dup_cyc,
                             input int rdy_wait, input int gap, output obs_t e);
        int first[3];
        logic [1:0] val[3];
        int ex, nhitm, m0;
        bit all, mem;
        logic [1:0] comb;
        logic [31:0] la;
        la = addr & 32'hFFFF_FFC0;
        e = '0; e.wr_hold = 1'b1; e.rdy_ok = 1'b1; e.op_ok = 1'b1; e.resp_cnt = 1;
        mem = 0; m0 = 0;
        if (op == 3'd2) begin
            mem = 1; m0 = 1; e.mem_write = 1'b1;
        end else if (op == 3'd1 || op == 3'd3 || op == 3'd4) begin
            all = 1; ex = 0;
            for (int i = 0; i < 3; i++) begin
                first[i] = 0; val[i] = 2'd0;
                if (rc_s[i] >= 2 && rc_s[i] <= 1 + T) begin
                    first[i] = rc_s[i]; val[i] = (rv_s[i] == 2'd3) ? 2'd0 : rv_s[i];
                end
                if (i == 0 && dup_cyc >= 2 && dup_cyc <= 1 + T && (first[0] == 0 || dup_cyc < first[0])) begin
                    first[0] = dup_cyc; val[0] = 2'd1;
                end
                if (first[i] == 0) all = 0;
                else if (first[i] > ex) ex = first[i];
            end
            if (!all) ex = 1 + T;
            comb = 2'd0; nhitm = 0;
            for (int i = 0; i < 3; i++) begin
                if (first[i] != 0 && first[i] <= ex) begin
                    if (val[i] > comb) comb = val[i];
                    if (val[i] == 2'd2) nhitm++;
                end
            end
            e.snp_cnt = 1; e.snp_cyc = 1; e.snp_addr = la; e.snoop = comb;
            if (nhitm > 1) exp_proto = 1'b1;
            if (!all) exp_tmo = exp_tmo + 32'd1;
            if (op == 3'd3) begin
                e.resp_cyc = ex + 1;
            end else begin
                mem = 1; m0 = ex + 1; e.mem_write = (comb == 2'd2);
                if (comb == 2'd2) exp_hitm = exp_hitm + 32'd1;
            end
        end else begin
            e.resp_cyc = 1;
        end
        if (mem) begin
            e.mem_first = m0; e.mem_cnt = rdy_wait + 1; e.mem_addr = la;
            e.resp_cyc = m0 + rdy_wait + gap + 1;
        end
    endtask

    // Drives one transaction (acting as LLC, snoopers and memory) and records what the DUT did
    task automatic drive_txn(input logic [2:0] op, input logic [31:0] addr, input int dup_cyc,
                             input int rdy_wait, input int gap, input int stray, output obs_t o);
        int w, done_cyc;
        o = '0; o.wr_hold = 1'b1; o.rdy_ok = 1'b1; o.op_ok = 1'b1;
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
        req_valid = 1'b1; req_op = op; req_addr = addr;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'($urandom); req_addr = $urandom;
        done_cyc = -1;
        for (int cyc = 1; cyc <= MAXC; cyc++) begin
            if (snp_valid) begin
                o.snp_cnt++;
                if (o.snp_cyc == 0) begin o.snp_cyc = cyc; o.snp_addr = snp_addr; end
            end
            if (mem_cmd_valid) begin
                if (o.mem_cnt == 0) begin
                    o.mem_first = cyc; o.mem_write = mem_cmd_write; o.mem_addr = mem_cmd_addr;
                end else if (mem_cmd_write !== o.mem_write) o.wr_hold = 1'b0;
                o.mem_cnt++;
            end
            if (resp_valid) begin
                o.resp_cnt++;
                if (o.resp_cyc == 0) begin o.resp_cyc = cyc; o.snoop = resp_snoop; end
            end
            if (o.resp_cyc != 0 && cyc == o.resp_cyc + 1) begin
                if (req_ready !== 1'b1 || resp_valid !== 1'b0) o.rdy_ok = 1'b0;
                break;
            end
            if (req_ready !== 1'b0) o.rdy_ok = 1'b0;
            if (snp_op !== op) o.op_ok = 1'b0;
            snp_resp_valid = '0;
            snp_resp = 6'($urandom);
            for (int i = 0; i < 3; i++) begin
                if (rc_s[i] == cyc) begin
                    snp_resp_valid[i] = 1'b1; snp_resp[2*i +: 2] = rv_s[i];
                end
            end
            if (dup_cyc == cyc) begin snp_resp_valid[0] = 1'b1; snp_resp[1:0] = 2'd1; end
            mem_cmd_ready = 1'b0;
            if (mem_cmd_valid && o.mem_cnt > rdy_wait) begin
                mem_cmd_ready = 1'b1;
                if (done_cyc < 0) done_cyc = cyc + gap;
            end
            mem_done = (cyc == done_cyc) || (cyc == stray);
            @(posedge clk); #1;
        end
        snp_resp_valid = '0; mem_cmd_ready = 1'b0; mem_done = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({req_ready, resp_valid, snp_valid, mem_cmd_valid, mem_cmd_write, proto_err} !== 6'b100000) begin
            n_err++; $display("FAIL reset_ctl: got %b want 100000",
                              {req_ready, resp_valid, snp_valid, mem_cmd_valid, mem_cmd_write, proto_err});
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({snp_op, snp_addr, mem_cmd_addr, resp_snoop, cnt_hitm, cnt_timeout, req_ready} !== {133'd0, 1'b1}) begin
            n_err++; $display("FAIL reset_data: op=%0d addr=%h maddr=%h snoop=%0d hitm=%0d tmo=%0d rdy=%b",
                              snp_op, snp_addr, mem_cmd_addr, resp_snoop, cnt_hitm, cnt_timeout, req_ready);
        end
    endtask

    task automatic test_invalidate;
        obs_t o, e;
        set_sched(2, 2, 2, 2'd0, 2'd0, 2'd0);
        model_txn(3'd3, 32'h0000_1040, 0, 0, 1, e);
        drive_txn(3'd3, 32'h0000_1040, 0, 0, 1, 0, o);
        n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL inv_txn: got %s want %s", fmt(o), fmt(e)); end
        n_cmp++;
        if (o.resp_cyc != 3 || o.snp_cyc != 1 || o.snp_addr !== 32'h0000_1040 || o.mem_cnt != 0 || o.snoop !== 2'd0) begin
            n_err++; $display("FAIL inv_fixed: got %s", fmt(o));
        end
    endtask

    task automatic test_read_hitm;
        obs_t o, e;
        set_sched(2, 3, 4, 2'd1, 2'd0, 2'd2);
        model_txn(3'd1, 32'h0000_207F, 0, 0, 1, e);
        drive_txn(3'd1, 32'h0000_207F, 0, 0, 1, 0, o);
        n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL read_hitm_txn: got %s want %s", fmt(o), fmt(e)); end
        n_cmp++;
        if (o.mem_write !== 1'b1 || o.mem_addr !== 32'h0000_2040 || o.snoop !== 2'd2 || cnt_hitm !== 32'd1) begin
            n_err++; $display("FAIL read_hitm_fixed: got %s hitm=%0d want wr=1 maddr=00002040 snoop=2 hitm=1", fmt(o), cnt_hitm);
        end
    endtask

    task automatic test_timeout;
        obs_t o, e;
        logic [31:0] a;
        a = $urandom;
        set_sched(2, 3, 0, 2'd1, 2'd1, 2'd0);
        model_txn(3'd4, a, 0, 0, 2, e);
        drive_txn(3'd4, a, 0, 0, 2, 0, o);
        n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL timeout_txn: got %s want %s", fmt(o), fmt(e)); end
        n_cmp++;
        if (o.mem_first != 2 + T || o.mem_write !== 1'b0 || o.snoop !== 2'd1 || cnt_timeout !== 32'd1) begin
            n_err++; $display("FAIL timeout_fixed: got %s tmo=%0d want mem@10 wr=0 snoop=1 tmo=1", fmt(o), cnt_timeout);
        end
    endtask

    task automatic test_write;
        obs_t o, e;
        set_sched(1, 2, 3, 2'd2, 2'd2, 2'd2);
        model_txn(3'd2, 32'h0000_3000, 0, 3, 2, e);
        drive_txn(3'd2, 32'h0000_3000, 0, 3, 2, 2, o);
        n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL write_txn: got %s want %s", fmt(o), fmt(e)); end
        n_cmp++;
        if (o.snp_cnt != 0 || o.mem_cnt != 4 || o.mem_write !== 1'b1 || o.wr_hold !== 1'b1 || o.snoop !== 2'd0 || o.resp_cyc != 7) begin
            n_err++; $display("FAIL write_fixed: got %s want mem x4 wr=1 snoop=0 resp@7", fmt(o));
        end
        // mem_done coinciding with the command handshake must be ignored
        set_sched(2, 2, 2, 2'd3, 2'd0, 2'd1);
        model_txn(3'd1, 32'h0000_5123, 0, 0, 2, e);
        drive_txn(3'd1, 32'h0000_5123, 0, 0, 2, 3, o);
        n_cmp++;
        if (o !== e || o.resp_cyc != 6) begin n_err++; $display("FAIL done_at_handshake: got %s want %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_proto_err;
        obs_t o, e;
        set_sched(2, 3, 4, 2'd0, 2'd2, 2'd2);
        model_txn(3'd1, 32'h0000_6000, 3, 1, 1, e);
        drive_txn(3'd1, 32'h0000_6000, 3, 1, 1, 0, o);
        n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL proto_txn: got %s want %s", fmt(o), fmt(e)); end
        n_cmp++;
        if (proto_err !== 1'b1 || o.snoop !== 2'd2) begin
            n_err++; $display("FAIL proto_set: proto_err=%b snoop=%0d want 1 and 2", proto_err, o.snoop);
        end
        set_sched(2, 2, 2, 2'd0, 2'd0, 2'd0);
        model_txn(3'd3, 32'h0000_6040, 0, 0, 1, e);
        drive_txn(3'd3, 32'h0000_6040, 0, 0, 1, 0, o);
        n_cmp++;
        if (proto_err !== 1'b1) begin n_err++; $display("FAIL proto_sticky: proto_err=%b want 1", proto_err); end
    endtask

    task automatic test_reset_midtxn;
        obs_t o, e;
        int bad;
        while (req_ready !== 1'b1) begin @(posedge clk); #1; end
        req_valid = 1'b1; req_op = 3'd1; req_addr = 32'h0000_4000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        snp_resp_valid = 3'b111; snp_resp = 6'd0; mem_cmd_ready = 1'b1;
        @(posedge clk); #1;
        snp_resp_valid = '0;
        @(posedge clk); #1;
        mem_cmd_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({req_ready, resp_valid, snp_valid, mem_cmd_valid, mem_cmd_write, proto_err,
             snp_op, snp_addr, mem_cmd_addr, resp_snoop, cnt_hitm, cnt_timeout} !== {6'b100000, 133'd0}) begin
            n_err++; $display("FAIL midreset_values: rdy=%b rv=%b sv=%b mv=%b perr=%b op=%0d addr=%h hitm=%0d tmo=%0d",
                              req_ready, resp_valid, snp_valid, mem_cmd_valid, proto_err, snp_op, snp_addr, cnt_hitm, cnt_timeout);
        end
        exp_hitm = '0; exp_tmo = '0; exp_proto = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        mem_done = 1'b1;
        @(posedge clk); #1;
        mem_done = 1'b0;
        bad = 0;
        repeat (6) begin
            if (resp_valid !== 1'b0 || mem_cmd_valid !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL midreset_abandon: %0d cycles with resp/mem activity, want 0", bad); end
        set_sched(2, 3, 2, 2'd1, 2'd0, 2'd0);
        model_txn(3'd1, 32'h0000_4000, 0, 1, 2, e);
        drive_txn(3'd1, 32'h0000_4000, 0, 1, 2, 0, o);
        n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL midreset_recover: got %s want %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_back_to_back_random;
        obs_t o, e;
        logic [2:0] op;
        logic [31:0] a;
        int r, rw, gp;
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            for (int i = 0; i < 3; i++) begin
                r = $urandom_range(0, 15);
                if (r < 2)        rc_s[i] = 0;
                else if (r == 2)  rc_s[i] = 1;
                else if (r >= 13) rc_s[i] = $urandom_range(10, 12);
                else              rc_s[i] = $urandom_range(2, 8);
                rv_s[i] = 2'($urandom_range(0, 3));
            end
            rw = $urandom_range(0, 3);
            gp = $urandom_range(1, 3);
            model_txn(op, a, 0, rw, gp, e);
            drive_txn(op, a, 0, rw, gp, 0, o);
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL rand_txn[%0d] op=%0d: got %s want %s", n, op, fmt(o), fmt(e)); end
            n_cmp++;
            if (proto_err !== exp_proto || cnt_hitm !== exp_hitm || cnt_timeout !== exp_tmo) begin
                n_err++; $display("FAIL rand_status[%0d]: perr=%b hitm=%0d tmo=%0d want %b %0d %0d",
                                  n, proto_err, cnt_hitm, cnt_timeout, exp_proto, exp_hitm, exp_tmo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_invalidate();
        test_read_hitm();
        test_timeout();
        test_write();
        test_proto_err();
        test_reset_midtxn();
        test_back_to_back_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
